// File: rtl/reg_writeback_ctrl_pkg.sv
// Shared types for the integer register write-back path.
// Result width, register count and the load-return entry.
package reg_writeback_ctrl_pkg;
  localparam int XLEN      = 64;
  localparam int NREG      = 32;
  localparam int REG_IDX_W = 5;

  typedef struct packed {
    logic [REG_IDX_W-1:0] rd;
    logic [XLEN-1:0]      data;
  } wb_entry_t;
endpackage

// File: rtl/wb_load_fifo.sv
// Load-return buffer: small FIFO of {rd, data} entries.
// Registered count drives full/empty; storage is not reset.
module wb_load_fifo
  import reg_writeback_ctrl_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  wb_entry_t              din,
  input  logic                   pop,
  output wb_entry_t              head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] PONE = 1;
  localparam logic [CW-1:0] CONE = 1;

  wb_entry_t       mem [DEPTH];
  logic [AW-1:0]   wp;
  logic [AW-1:0]   rp;

  always_ff @(posedge clk) begin
    if (push) mem[wp] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push) wp <= wp + PONE;
      if (pop)  rp <= rp + PONE;
      case ({push, pop})
        2'b10:   count <= count + CONE;
        2'b01:   count <= count - CONE;
        default: ;
      endcase
    end
  end

  assign head  = mem[rp];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
endmodule

// File: rtl/reg_writeback_ctrl.sv
// Write-side controller: merges ALU and load returns into one
// registered register-file write port and tracks busy registers.
module reg_writeback_ctrl
  import reg_writeback_ctrl_pkg::*;
#(
  parameter int LQ_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 issue_valid,
  input  logic [REG_IDX_W-1:0] issue_rd,
  input  logic                 alu_valid,
  output logic                 alu_ready,
  input  logic [REG_IDX_W-1:0] alu_rd,
  input  logic [XLEN-1:0]      alu_data,
  input  logic                 ld_valid,
  output logic                 ld_ready,
  input  logic [REG_IDX_W-1:0] ld_rd,
  input  logic [XLEN-1:0]      ld_data,
  input  logic [REG_IDX_W-1:0] chk_rs1,
  input  logic [REG_IDX_W-1:0] chk_rs2,
  output logic                 hazard,
  output logic [NREG-1:0]      busy,
  output logic                 regWrite,
  output logic [REG_IDX_W-1:0] rd,
  output logic [XLEN-1:0]      WriteData
);
  localparam int CW = $clog2(LQ_DEPTH) + 1;

  logic          lq_full;
  logic          lq_empty;
  logic          lq_push;
  logic          lq_pop;
  logic [CW-1:0] lq_count;
  wb_entry_t     lq_head;
  wb_entry_t     alu_e;
  wb_entry_t     ld_e;
  wb_entry_t     sel;
  logic          sel_v;
  logic          launch;
  logic          room;
  logic [NREG-1:0] busy_nxt;

  assign alu_e = '{rd: alu_rd, data: alu_data};
  assign ld_e  = '{rd: ld_rd, data: ld_data};

  assign room      = !reset && (lq_count != CW'(LQ_DEPTH));
  assign alu_ready = room;
  assign ld_ready  = room;
  assign lq_push   = ld_valid && room;

  wb_load_fifo #(.DEPTH(LQ_DEPTH)) u_lq (
    .clk   (clk),
    .reset (reset),
    .push  (lq_push),
    .din   (ld_e),
    .pop   (lq_pop),
    .head  (lq_head),
    .full  (lq_full),
    .empty (lq_empty),
    .count (lq_count)
  );

  // A full queue outranks the ALU so loads cannot starve.
  always_comb begin
    sel_v  = 1'b0;
    sel    = lq_head;
    lq_pop = 1'b0;
    if (!reset) begin
      priority case (1'b1)
        lq_full: begin
          sel_v  = 1'b1;
          lq_pop = 1'b1;
        end
        alu_valid: begin
          sel_v = 1'b1;
          sel   = alu_e;
        end
        !lq_empty: begin
          sel_v  = 1'b1;
          lq_pop = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign launch = sel_v && (sel.rd != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      regWrite  <= 1'b0;
      rd        <= '0;
      WriteData <= '0;
    end else begin
      regWrite <= launch;
      if (launch) begin
        rd        <= sel.rd;
        WriteData <= sel.data;
      end
    end
  end

  // Set after clear: a newly issued producer wins the collision.
  always_comb begin
    busy_nxt = busy;
    if (launch) busy_nxt[sel.rd] = 1'b0;
    if (issue_valid && issue_rd != '0) busy_nxt[issue_rd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) busy <= '0;
    else       busy <= busy_nxt;
  end

  assign hazard = (chk_rs1 != '0 && busy[chk_rs1]) ||
                  (chk_rs2 != '0 && busy[chk_rs2]);
endmodule

// File: tb/tb_reg_writeback_ctrl.sv
// Self-checking bench for reg_writeback_ctrl: directed table,
// multi-cycle corner sequences and randomized traffic vs a queue model.
module tb_reg_writeback_ctrl;
  import reg_writeback_ctrl_pkg::*;

  localparam int D = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic            issue_valid;
  logic [4:0]      issue_rd;
  logic            alu_valid;
  logic            alu_ready;
  logic [4:0]      alu_rd;
  logic [63:0]     alu_data;
  logic            ld_valid;
  logic            ld_ready;
  logic [4:0]      ld_rd;
  logic [63:0]     ld_data;
  logic [4:0]      chk_rs1;
  logic [4:0]      chk_rs2;
  logic            hazard;
  logic [31:0]     busy;
  logic            regWrite;
  logic [4:0]      rd;
  logic [63:0]     WriteData;

  reg_writeback_ctrl #(.LQ_DEPTH(D)) dut (
    .clk         (clk),
    .reset       (reset),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .alu_valid   (alu_valid),
    .alu_ready   (alu_ready),
    .alu_rd      (alu_rd),
    .alu_data    (alu_data),
    .ld_valid    (ld_valid),
    .ld_ready    (ld_ready),
    .ld_rd       (ld_rd),
    .ld_data     (ld_data),
    .chk_rs1     (chk_rs1),
    .chk_rs2     (chk_rs2),
    .hazard      (hazard),
    .busy        (busy),
    .regWrite    (regWrite),
    .rd          (rd),
    .WriteData   (WriteData)
  );

  always #5 clk = ~clk;

  int nerr = 0;
  int nchk = 0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Reference model: a queue for the load buffer and a bit array of
  // pending destinations; updated from the arbitration rules.
  wb_entry_t   mq[$];
  logic [31:0] mbusy = '0;
  logic        mrw = 1'b0;
  logic [4:0]  mrd = '0;
  logic [63:0] mwd = '0;
  bit          m_acc_alu;
  bit          m_acc_ld;

  wb_entry_t   aq[$];
  wb_entry_t   lsrc[$];
  int          wcnt[32];

  task automatic step();
    bit        ar;
    bit        have;
    bit        hz;
    wb_entry_t e;
    #1;
    ar = !reset && (mq.size() < D);
    hz = (chk_rs1 != 0 && mbusy[chk_rs1]) ||
         (chk_rs2 != 0 && mbusy[chk_rs2]);
    chk("alu_ready", alu_ready, ar);
    chk("ld_ready", ld_ready, ar);
    chk("busy", busy, mbusy);
    chk("hazard", hazard, hz);
    m_acc_alu = 0;
    m_acc_ld  = 0;
    if (reset) begin
      mq.delete();
      mbusy = '0;
      mrw = 0;
      mrd = '0;
      mwd = '0;
    end else begin
      have = 0;
      e = '0;
      if (mq.size() == D) begin
        e = mq.pop_front();
        have = 1;
      end else if (alu_valid) begin
        e = '{alu_rd, alu_data};
        have = 1;
      end else if (mq.size() > 0) begin
        e = mq.pop_front();
        have = 1;
      end
      m_acc_alu = alu_valid && ar;
      if (ld_valid && ar) begin
        mq.push_back('{ld_rd, ld_data});
        m_acc_ld = 1;
      end
      mrw = have && (e.rd != 0);
      if (mrw) begin
        mrd = e.rd;
        mwd = e.data;
        mbusy[e.rd] = 1'b0;
      end
      if (issue_valid && issue_rd != 0) mbusy[issue_rd] = 1'b1;
    end
    @(posedge clk);
    #1;
    chk("regWrite", regWrite, mrw);
    chk("rd", rd, mrd);
    chk("WriteData", WriteData, mwd);
    chk("busy_q", busy, mbusy);
  endtask

  task automatic cyc(bit iv, logic [4:0] ir);
    wb_entry_t t;
    issue_valid = iv;
    issue_rd    = ir;
    alu_valid   = aq.size() > 0;
    alu_rd      = alu_valid ? aq[0].rd : 5'd0;
    alu_data    = alu_valid ? aq[0].data : 64'd0;
    ld_valid    = lsrc.size() > 0;
    ld_rd       = ld_valid ? lsrc[0].rd : 5'd0;
    ld_data     = ld_valid ? lsrc[0].data : 64'd0;
    step();
    if (m_acc_alu) t = aq.pop_front();
    if (m_acc_ld)  t = lsrc.pop_front();
    if (regWrite) wcnt[rd]++;
  endtask

  task automatic idle();
    issue_valid = 0;
    issue_rd    = 0;
    alu_valid   = 0;
    alu_rd      = 0;
    alu_data    = 0;
    ld_valid    = 0;
    ld_rd       = 0;
    ld_data     = 0;
  endtask

  typedef struct {
    bit          iv;
    logic [4:0]  ir;
    bit          av;
    logic [4:0]  ard;
    logic [63:0] ad;
    bit          erw;
    logic [4:0]  erd;
    logic [63:0] ewd;
    logic [31:0] ebusy;
  } vec_t;

  vec_t tbl[7];

  initial begin
    int          leaked;
    int          n;
    bit          saw_stall;
    logic [4:0]  r;

    tbl[0] = '{1, 5, 0, 0,  64'h0,    0, 0,  64'h0,    32'h0000_0020};
    tbl[1] = '{0, 0, 1, 5,  64'hDEAD, 1, 5,  64'hDEAD, 32'h0000_0000};
    tbl[2] = '{0, 0, 1, 0,  64'hFF,   0, 5,  64'hDEAD, 32'h0000_0000};
    tbl[3] = '{1, 3, 1, 3,  64'h33,   1, 3,  64'h33,   32'h0000_0008};
    tbl[4] = '{0, 0, 0, 0,  64'h0,    0, 3,  64'h33,   32'h0000_0008};
    tbl[5] = '{1, 12, 1, 3, 64'h44,   1, 3,  64'h44,   32'h0000_1000};
    tbl[6] = '{0, 0, 1, 12, 64'h1,    1, 12, 64'h1,    32'h0000_0000};

    idle();
    chk_rs1 = 5;
    chk_rs2 = 3;
    reset = 1;
    step();
    step();
    chk("rst_regWrite", regWrite, 0);
    chk("rst_busy", busy, 0);
    reset = 0;

    foreach (tbl[i]) begin
      issue_valid = tbl[i].iv;
      issue_rd    = tbl[i].ir;
      alu_valid   = tbl[i].av;
      alu_rd      = tbl[i].ard;
      alu_data    = tbl[i].ad;
      step();
      chk($sformatf("tbl%0d_rw", i), regWrite, tbl[i].erw);
      chk($sformatf("tbl%0d_rd", i), rd, tbl[i].erd);
      chk($sformatf("tbl%0d_wd", i), WriteData, tbl[i].ewd);
      chk($sformatf("tbl%0d_busy", i), busy, tbl[i].ebusy);
    end

    // Load latency: accepted at one edge, written at the next.
    idle();
    ld_valid = 1;
    ld_rd    = 7;
    ld_data  = 64'h1234;
    step();
    chk("ld_lat1_rw", regWrite, 0);
    idle();
    step();
    chk("ld_lat2_rw", regWrite, 1);
    chk("ld_lat2_rd", rd, 7);
    chk("ld_lat2_wd", WriteData, 64'h1234);

    // Contention: ALU stream held while three loads arrive.
    foreach (wcnt[i]) wcnt[i] = 0;
    for (int i = 0; i < 6; i++)
      aq.push_back('{5'(20 + i), {$urandom, $urandom}});
    lsrc.push_back('{5'd8,  64'h8888});
    lsrc.push_back('{5'd9,  64'h9999});
    lsrc.push_back('{5'd10, 64'hAAAA});
    saw_stall = 0;
    n = 0;
    while ((aq.size() || lsrc.size() || mq.size()) && n < 60) begin
      if (aq.size() && mq.size() == D) begin
        #1;
        if (!alu_ready) saw_stall = 1;
      end
      cyc(0, 0);
      n++;
    end
    chk("cont_timeout", n < 60, 1);
    chk("cont_stall", saw_stall, 1);
    chk("cont_x8", wcnt[8], 1);
    chk("cont_x9", wcnt[9], 1);
    chk("cont_x10", wcnt[10], 1);
    for (int i = 20; i < 26; i++)
      chk($sformatf("cont_x%0d", i), wcnt[i], 1);
    idle();
    step();
    chk("cont_ldrdy", ld_ready, 1);

    // Reset with two queued loads and x9/x10 pending.
    issue_valid = 1; issue_rd = 9;
    alu_valid = 1; alu_rd = 0; alu_data = 64'hFF;
    ld_valid = 1; ld_rd = 9; ld_data = 64'h9;
    step();
    issue_rd = 10; ld_rd = 10; ld_data = 64'hA;
    step();
    chk("rm_busy", busy, 32'h0000_0600);
    chk("rm_full", ld_ready, 0);
    idle();
    reset = 1;
    step();
    chk("rm_rw", regWrite, 0);
    chk("rm_busy0", busy, 0);
    reset = 0;
    leaked = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (regWrite) leaked++;
    end
    chk("rm_leak", leaked, 0);

    // Randomized traffic against the model.
    for (int c = 0; c < 400; c++) begin
      if (aq.size() < 2 && $urandom_range(0, 99) < 50)
        aq.push_back('{5'($urandom), {$urandom, $urandom}});
      if (lsrc.size() < 2 && $urandom_range(0, 99) < 40)
        lsrc.push_back('{5'($urandom), {$urandom, $urandom}});
      chk_rs1 = 5'($urandom);
      chk_rs2 = 5'($urandom);
      r = 5'($urandom);
      cyc(($urandom_range(0, 1) == 1) && !mbusy[r], r);
    end
    n = 0;
    while ((aq.size() || lsrc.size() || mq.size()) && n < 40) begin
      cyc(0, 0);
      n++;
    end
    chk("rnd_drain", n < 40, 1);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
